// File: rtl/boot_test_ctrl.sv
// Boot and self-test controller for the single-cycle RISC-V core.
// Streams a program into imem and holds the core in reset while loading.
// It then runs the core until a store to tohost or until the watchdog
// expires, and reports the outcome.
module boot_test_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned IMEM_DEPTH     = 256,
  parameter int unsigned RST_HOLD       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_00FC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  input  logic              mon_we,
  input  logic [31:0]       mon_addr,
  input  logic [DATA_W-1:0] mon_wdata,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              trunc,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE} state_t;

  // The hold counter only has to reach RST_HOLD-1; keep at least one bit.
  localparam int unsigned HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic handshake_c;
  logic tohost_hit_c;
  logic hold_done_c;

  // Load handshake, tohost detection and end-of-hold decode.
  assign handshake_c  = ld_valid & ld_ready;
  assign tohost_hit_c = mon_we && (mon_addr == TOHOST_ADDR);
  // RST_HOLD of zero still spends a single cycle in HOLD.
  assign hold_done_c  = (32'(hold_cnt) + 32'd1) >= RST_HOLD;

  // Controller state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wptr       <= '0;
      hold_cnt   <= '0;
      ld_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      cycle_cnt  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      trunc      <= 1'b0;
      result     <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            ld_ready  <= 1'b1;
            wptr      <= '0;
            cycle_cnt <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            trunc     <= 1'b0;
            result    <= '0;
          end
        end
        LOAD: begin
          if (handshake_c) begin
            imem_we    <= 1'b1;
            imem_waddr <= wptr;
            imem_wdata <= ld_data;
            wptr       <= wptr + ADDR_W'(1);
            // Stop on the final word, or when imem is full without it.
            if (ld_last || (wptr == LAST_ADDR)) begin
              state    <= HOLD;
              ld_ready <= 1'b0;
              hold_cnt <= '0;
              trunc    <= ~ld_last;
            end
          end
        end
        HOLD: begin
          if (hold_done_c) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          // The tohost store takes priority over a coincident timeout.
          if (tohost_hit_c) begin
            state    <= DONE;
            core_rst <= 1'b1;
            done     <= 1'b1;
            result   <= mon_wdata;
            pass     <= (mon_wdata == DATA_W'(1));
            timeout  <= 1'b0;
          end else if (cycle_cnt == TO_LAST) begin
            state    <= DONE;
            core_rst <= 1'b1;
            done     <= 1'b1;
            pass     <= 1'b0;
            timeout  <= 1'b1;
          end else if (cycle_cnt != CNT_MAX) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_test_ctrl.sv
// Scoreboard bench for boot_test_ctrl: the driver queues expected imem
// writes and run outcomes, and a negedge monitor checks them as they appear.
module tb_boot_test_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned TO    = 25;
  localparam int unsigned CW    = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic          core_rst;
  logic          mon_we;
  logic [31:0]   mon_addr;
  logic [DW-1:0] mon_wdata;
  logic [CW-1:0] cycle_cnt;
  logic          done;
  logic          pass;
  logic          timeout;
  logic          trunc;
  logic [DW-1:0] result;

  boot_test_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .IMEM_DEPTH(DEPTH), .RST_HOLD(HOLD),
    .TIMEOUT_CYCLES(TO), .CNT_W(CW), .TOHOST_ADDR(32'h0000_00FC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst(core_rst),
    .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata),
    .cycle_cnt(cycle_cnt), .done(done), .pass(pass), .timeout(timeout),
    .trunc(trunc), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          pass;
    logic          timeout;
    logic          trunc;
    logic [DW-1:0] result;
    logic [CW-1:0] cnt;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_addr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes imem or finishes a run.
  initial begin : monitor
    logic done_d;
    wr_t  ew;
    res_t er;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && imem_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: actual addr 0x%0h data 0x%0h, required no write",
                   imem_waddr, imem_wdata);
        end else begin
          ew = wr_q.pop_front();
          chk("imem_waddr", 64'(imem_waddr), 64'(ew.addr));
          chk("imem_wdata", 64'(imem_wdata), 64'(ew.data));
        end
      end
      if (rst === 1'b1 && done === 1'b1 && !done_d) begin
        if (res_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: actual done 1, required 0");
        end else begin
          er = res_q.pop_front();
          chk("res_pass",    64'(pass),      64'(er.pass));
          chk("res_timeout", 64'(timeout),   64'(er.timeout));
          chk("res_trunc",   64'(trunc),     64'(er.trunc));
          chk("res_result",  64'(result),    64'(er.result));
          chk("res_cnt",     64'(cycle_cnt), 64'(er.cnt));
          chk("res_core_rst", 64'(core_rst), 64'd1);
        end
      end
      done_d = (done === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic exp_res(input logic p, input logic t, input logic tr,
                         input logic [DW-1:0] r, input logic [CW-1:0] c);
    res_t e;
    e.pass = p; e.timeout = t; e.trunc = tr; e.result = r; e.cnt = c;
    res_q.push_back(e);
  endtask

  // Offer one word and wait (bounded) for it to be accepted.
  task automatic send(input logic [DW-1:0] d, input logic last);
    int  n;
    wr_t e;
    n = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    while (!ld_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ld_ready) begin
      chk("ld_ready_wait", 64'(ld_ready), 64'd1);
    end else begin
      e.addr = AW'(exp_addr);
      e.data = d;
      wr_q.push_back(e);
      exp_addr++;
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (core_rst && n < 50) begin
      tick();
      n++;
    end
    chk("enter_run", 64'(core_rst), 64'd0);
  endtask

  task automatic wait_cnt(input int k);
    int n;
    n = 0;
    while (cycle_cnt != CW'(k) && !done && n < 100) begin
      tick();
      n++;
    end
    chk("reach_cnt", 64'(cycle_cnt), 64'(k));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic store(input logic [31:0] a, input logic [DW-1:0] d);
    mon_we    = 1'b1;
    mon_addr  = a;
    mon_wdata = d;
    tick();
    mon_we    = 1'b0;
    mon_addr  = '0;
    mon_wdata = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_core_rst"},  64'(core_rst),  64'd1);
    chk({tag, "_ld_ready"},  64'(ld_ready),  64'd0);
    chk({tag, "_imem_we"},   64'(imem_we),   64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
    chk({tag, "_pass"},      64'(pass),      64'd0);
    chk({tag, "_timeout"},   64'(timeout),   64'd0);
    chk({tag, "_trunc"},     64'(trunc),     64'd0);
    chk({tag, "_result"},    64'(result),    64'd0);
    chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: actual still running, required finished");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin : driver
    int n;
    rst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    mon_we = 1'b0; mon_addr = '0; mon_wdata = '0;
    tick();
    tick();
    chk_reset("por");
    rst = 1'b1;
    tick();

    // Reset in the middle of a load aborts to IDLE.
    do_start();
    exp_addr = 0;
    send(32'h0000_0011, 1'b0);
    send(32'h0000_0022, 1'b0);
    send(32'h0000_0033, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk_reset("midload");
    tick();
    rst = 1'b1;
    tick();
    chk("idle_ld_ready", 64'(ld_ready), 64'd0);
    chk("idle_core_rst", 64'(core_rst), 64'd1);

    // Full program load, reset hold, pass run with distractions.
    do_start();
    chk("load_ld_ready", 64'(ld_ready), 64'd1);
    exp_addr = 0;
    send(32'h0050_0093, 1'b0);
    send(32'h0010_0113, 1'b0);
    send(32'h0E20_2E23, 1'b0);
    send(32'h0000_006F, 1'b1);
    chk("last_ld_ready", 64'(ld_ready), 64'd0);
    n = 0;
    while (core_rst && n < 20) begin
      n++;
      tick();
    end
    chk("hold_cycles", 64'(n), 64'(HOLD));
    chk("run_cnt0", 64'(cycle_cnt), 64'd0);
    wait_cnt(5);
    store(32'h0000_00F8, 32'd1);
    chk("other_store_ignored", 64'(done), 64'd0);
    wait_cnt(10);
    do_start();
    chk("start_in_run_core_rst", 64'(core_rst), 64'd0);
    chk("start_in_run_ld_ready", 64'(ld_ready), 64'd0);
    wait_cnt(20);
    exp_res(1'b1, 1'b0, 1'b0, 32'd1, 32'd20);
    store(32'h0000_00FC, 32'd1);
    chk("pass_done", 64'(done), 64'd1);
    tick(); tick(); tick();
    chk("frozen_cnt", 64'(cycle_cnt), 64'd20);
    chk("frozen_done", 64'(done), 64'd1);

    // Restart from DONE, back-pressured load, failing result.
    do_start();
    chk("restart_done",   64'(done),      64'd0);
    chk("restart_pass",   64'(pass),      64'd0);
    chk("restart_result", 64'(result),    64'd0);
    chk("restart_cnt",    64'(cycle_cnt), 64'd0);
    chk("restart_ready",  64'(ld_ready),  64'd1);
    exp_addr = 0;
    send(32'hA000_0000, 1'b0); tick();
    send(32'hA000_0001, 1'b0); tick();
    send(32'hA000_0002, 1'b0); tick();
    send(32'hA000_0003, 1'b1); tick();
    wait_run();
    wait_cnt(3);
    exp_res(1'b0, 1'b0, 1'b0, 32'd7, 32'd3);
    store(32'h0000_00FC, 32'd7);
    wait_done();

    // Tohost store in the same cycle as the watchdog: tohost wins.
    do_start();
    exp_addr = 0;
    send(32'h1234_5678, 1'b1);
    wait_run();
    wait_cnt(TO - 1);
    exp_res(1'b1, 1'b0, 1'b0, 32'd1, CW'(TO - 1));
    store(32'h0000_00FC, 32'd1);
    chk("collision_timeout", 64'(timeout), 64'd0);

    // No store at all: watchdog ends the run.
    do_start();
    exp_addr = 0;
    send(32'hDEAD_BEEF, 1'b1);
    exp_res(1'b0, 1'b1, 1'b0, 32'd0, CW'(TO - 1));
    wait_run();
    wait_done();

    // Program longer than imem: truncated after DEPTH words, run proceeds.
    do_start();
    exp_addr = 0;
    send(32'hB000_0000, 1'b0);
    send(32'hB000_0001, 1'b0);
    send(32'hB000_0002, 1'b0);
    send(32'hB000_0003, 1'b0);
    chk("ovf_ld_ready", 64'(ld_ready), 64'd0);
    chk("ovf_trunc", 64'(trunc), 64'd1);
    ld_valid = 1'b1;
    ld_data  = 32'hB000_0004;
    tick(); tick();
    ld_data  = 32'hB000_0005;
    tick();
    chk("ovf_ld_ready_held", 64'(ld_ready), 64'd0);
    ld_valid = 1'b0;
    exp_res(1'b0, 1'b1, 1'b1, 32'd0, CW'(TO - 1));
    wait_run();
    wait_done();

    tick(); tick();
    chk("wr_q_drained",  64'(wr_q.size()),  64'd0);
    chk("res_q_drained", 64'(res_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
